hdlc_rx_monitor: RTL and testbench
==================================

# hdlc_rx_monitor

Synthesizable, multi-channel HDLC receive-side protocol monitor. Each channel snoops one serial Rx line and the Rx controller's status strobes, runs its own framing model (flag, abort, frame length), and checks flag-detect latency, abort signalling, end-of-frame and overflow behaviour. Mismatches go into saturating error counters and per-channel sticky flags. The block sits beside the Rx controller on silicon or FPGA builds, where simulation-only checks are not available.

## Interface
- CHANNELS, default 1: number of independent monitored Rx channels.
- MAX_BYTES, default 128: frame payload capacity; byte MAX_BYTES+1 must raise overflow.
- FLAG_LAT, default 2: required cycles from flag completion to Rx_FlagDetect.
- ABORT_WIN, default 2: window, in cycles, for Rx_AbortSignal after an abort pattern.
- CNT_W, default 16: error and frame counter width.

Ports:
- Clk  in  1  system clock; everything is on the rising edge.
- Rst  in  1  reset; synchronous, active-high.
- Clr  in  1  synchronous clear of counters and sticky flags; channel models are not affected.
- Rx  in  CHANNELS  serial receive bit per channel.
- Rx_FlagDetect, Rx_AbortSignal, Rx_EoF, Rx_Overflow, Rx_ValidFrame, Rx_NewByte  in  CHANNELS each  DUT status, one bit per channel.
- ErrFlagCnt, ErrAbortCnt, ErrEoFCnt, ErrOvfCnt  out  CNT_W each  error totals summed over all channels.
- FrameCnt  out  CNT_W  closed, non-aborted frames summed over all channels.
- ErrSticky  out  CHANNELS  per-channel "any error seen" flag.

## Operation
- Per channel, an 8-bit history register shifts in Rx every cycle. A fill counter (0..8) inhibits all pattern matches until 8 bits have been received since reset.
- Flag: history, oldest to newest, equals 0111_1110.
- Abort pattern: 0111_1111.
- Per-channel framing FSM, with HUNT as the reset state:
  - HUNT: on flag, go to OPEN.
  - OPEN: flag stays in OPEN; Rx_NewByte goes to FRAME and sets the byte count to 1; abort pattern goes to HUNT with no abort check.
  - FRAME: flag goes to OPEN and increments FrameCnt; abort pattern goes to HUNT and arms the abort check; each Rx_NewByte increments the byte count.
- Byte count is 8 bits wide plus margin, saturates at MAX_BYTES+1, and clears on entering OPEN or HUNT.
- Flag check:
  - Each flag match pushes an expectation into a FLAG_LAT-deep shift pipe.
  - Pipe output high and Rx_FlagDetect low counts as a missed-flag error.
  - Rx_FlagDetect high and pipe output low counts as a spurious-flag error.
  - Both kinds go to ErrFlagCnt.
- Abort check: once armed, a down-counter loads ABORT_WIN. Rx_AbortSignal high while the counter is nonzero disarms it. Reaching 0 while still armed counts one ErrAbort. A re-arm while armed restarts the window.
- EoF check: Rx_ValidFrame falling (high at t-1, low at t) requires Rx_EoF high at t+1; otherwise ErrEoF.
- Overflow check: byte count reaching MAX_BYTES+1 at t requires Rx_Overflow high at t+1; otherwise ErrOvf. This is checked once per frame.
- Aggregation: each counter adds the popcount of that class's per-channel error strobes in the cycle. Additions saturate at 2^CNT_W-1 and never wrap.
- Any error strobe on channel c sets ErrSticky[c].
- Clr and new errors in the same cycle: the counter loads that cycle's increment and not 0. Sticky flags load that cycle's strobes.

## Timing
- Reset values: all counters 0, ErrSticky 0, FSMs in HUNT, fill counters 0, flag pipes empty, abort checks disarmed, byte counts 0.
- Rst asserted mid-frame discards all pending expectations; no error is reported for them.
- Flag completed on the edge at t: Rx_FlagDetect is sampled at t+FLAG_LAT.
- Error strobes register in the checking cycle. Counters and ErrSticky update on the next edge, so observed latency is 1 cycle after the failing sample.
- Back-to-back flags sharing a zero (0111111011111 10) give two expectations, FLAG_LAT cycles apart from their respective completions.
- An abort pattern in OPEN or HUNT raises no abort check. Seven or more consecutive ones re-match the abort pattern only after a 0 re-enters the history.
- All channels are fully independent; only the counter summation is shared.

## Test plan
- Flag then 3 data bytes then flag on channel 0, with the DUT correct → FrameCnt=1 and all error counts 0.
- Rx_FlagDetect delayed to 3 cycles (FLAG_LAT=2), single flag → ErrFlagCnt=2 (one missed, one spurious) and ErrSticky[0]=1.
- Abort pattern in FRAME with Rx_AbortSignal held low → ErrAbortCnt=1 at ABORT_WIN+1 cycles after the match. Repeat with AbortSignal at +1 → count stays 0.
- CHANNELS=4, MAX_BYTES=128, 129 Rx_NewByte pulses on channels 1 and 3 with no Rx_Overflow → ErrOvfCnt=2 in a single update and ErrSticky=4'b1010.
- CNT_W=4, 20 Rx_ValidFrame falls without Rx_EoF → ErrEoFCnt saturates at 15. Clr in the same cycle as a new error → 1.
- Rst pulsed 1 cycle after a flag completes → no ErrFlag, FSM in HUNT, and the fill counter blocks matches for 8 cycles.

Source files
------------

// File: rtl/hdlc_rx_monitor_if.sv
// Bundle of snooped Rx-controller signals and monitor result outputs.
// The master side drives the line/status; the monitor uses the slave side.
interface hdlc_rx_monitor_if #(
  parameter int CHANNELS = 1,
  parameter int CNT_W    = 16
);
  logic [CHANNELS-1:0] Rx;
  logic [CHANNELS-1:0] Rx_FlagDetect;
  logic [CHANNELS-1:0] Rx_AbortSignal;
  logic [CHANNELS-1:0] Rx_EoF;
  logic [CHANNELS-1:0] Rx_Overflow;
  logic [CHANNELS-1:0] Rx_ValidFrame;
  logic [CHANNELS-1:0] Rx_NewByte;
  logic [CNT_W-1:0]    ErrFlagCnt;
  logic [CNT_W-1:0]    ErrAbortCnt;
  logic [CNT_W-1:0]    ErrEoFCnt;
  logic [CNT_W-1:0]    ErrOvfCnt;
  logic [CNT_W-1:0]    FrameCnt;
  logic [CHANNELS-1:0] ErrSticky;

  modport master (
    output Rx, Rx_FlagDetect, Rx_AbortSignal, Rx_EoF, Rx_Overflow, Rx_ValidFrame, Rx_NewByte,
    input  ErrFlagCnt, ErrAbortCnt, ErrEoFCnt, ErrOvfCnt, FrameCnt, ErrSticky
  );

  modport slave (
    input  Rx, Rx_FlagDetect, Rx_AbortSignal, Rx_EoF, Rx_Overflow, Rx_ValidFrame, Rx_NewByte,
    output ErrFlagCnt, ErrAbortCnt, ErrEoFCnt, ErrOvfCnt, FrameCnt, ErrSticky
  );
endinterface

// File: rtl/hdlc_rx_monitor.sv
// Multi-channel HDLC receive monitor: per-channel framing model and status checks,
// with saturating error/frame totals and per-channel sticky error flags.
module hdlc_rx_monitor #(
  parameter int CHANNELS  = 1,
  parameter int MAX_BYTES = 128,
  parameter int FLAG_LAT  = 2,
  parameter int ABORT_WIN = 2,
  parameter int CNT_W     = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Clr,
  hdlc_rx_monitor_if.slave mon
);
  localparam int BC_W  = $clog2(MAX_BYTES + 2) + 1;
  localparam int AW_W  = $clog2(ABORT_WIN + 1);
  localparam int PC_W  = $clog2(CHANNELS + 1);
  localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
  localparam logic [7:0]       FLAG_PAT  = 8'h7E;
  localparam logic [7:0]       ABORT_PAT = 8'h7F;
  localparam logic [BC_W-1:0]  BC_FULL   = BC_W'(MAX_BYTES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {HUNT, OPEN, FRAME} state_t;

  logic [CHANNELS-1:0] err_flag, err_abort, err_eof, err_ovf, frame_close;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    state_t              state_q, state_d;
    logic [7:0]          hist_q, hist_d;
    logic [3:0]          fill_q, fill_d;
    logic [FLAG_LAT-1:0] pipe_q, pipe_d;
    logic [BC_W-1:0]     bc_q, bc_d;
    logic                bc_full_q, bc_full_d;
    logic                ovf_chk_q, ovf_chk_d;
    logic                arm_q, arm_d;
    logic [AW_W-1:0]     acnt_q, acnt_d;
    logic                vf_q, vf_d;
    logic                eof_chk_q, eof_chk_d;
    logic                flag_hit, abort_hit, new_byte;
    logic                arm_evt, close_evt, bc_load1, bc_inc;
    logic                ch_err_abort;

    // Nothing matches until a full byte has been shifted in since reset.
    assign flag_hit  = (fill_q == 4'd8) && (hist_q == FLAG_PAT);
    assign abort_hit = (fill_q == 4'd8) && (hist_q == ABORT_PAT);
    assign new_byte  = mon.Rx_NewByte[gi];

    always_ff @(posedge Clk) begin
      if (Rst) begin
        state_q <= HUNT;
      end else begin
        state_q <= state_d;
      end
    end

    always_comb begin
      state_d = state_q;
      case (state_q)
        HUNT:    if (flag_hit) state_d = OPEN;
        OPEN: begin
          if (abort_hit)                  state_d = HUNT;
          else if (!flag_hit && new_byte) state_d = FRAME;
        end
        FRAME: begin
          if (abort_hit)     state_d = HUNT;
          else if (flag_hit) state_d = OPEN;
        end
        default: state_d = HUNT;
      endcase
    end

    always_comb begin
      arm_evt   = 1'b0;
      close_evt = 1'b0;
      bc_load1  = 1'b0;
      bc_inc    = 1'b0;
      case (state_q)
        OPEN:  bc_load1 = !abort_hit && !flag_hit && new_byte;
        FRAME: begin
          arm_evt   = abort_hit;
          close_evt = !abort_hit && flag_hit;
          bc_inc    = !abort_hit && !flag_hit && new_byte;
        end
        default: ;
      endcase
    end

    always_comb begin
      hist_d = {hist_q[6:0], mon.Rx[gi]};
      fill_d = (fill_q == 4'd8) ? fill_q : fill_q + 4'd1;
      pipe_d = FLAG_LAT'({pipe_q, flag_hit});

      if (state_d != FRAME)                  bc_d = '0;
      else if (bc_load1)                     bc_d = BC_W'(1);
      else if (bc_inc && (bc_q != BC_FULL))  bc_d = bc_q + BC_W'(1);
      else                                   bc_d = bc_q;

      // The first cycle at the saturated count schedules one overflow check.
      bc_full_d = (bc_q == BC_FULL);
      ovf_chk_d = (bc_q == BC_FULL) && !bc_full_q;

      vf_d      = mon.Rx_ValidFrame[gi];
      eof_chk_d = vf_q && !mon.Rx_ValidFrame[gi];

      arm_d        = arm_q;
      acnt_d       = acnt_q;
      ch_err_abort = 1'b0;
      if (arm_q) begin
        if (acnt_q == '0) begin
          ch_err_abort = 1'b1;
          arm_d        = 1'b0;
        end else begin
          acnt_d = acnt_q - AW_W'(1);
          if (mon.Rx_AbortSignal[gi]) arm_d = 1'b0;
        end
      end
      if (arm_evt) begin
        arm_d  = 1'b1;
        acnt_d = AW_W'(ABORT_WIN);
      end
    end

    always_ff @(posedge Clk) begin
      if (Rst) begin
        hist_q    <= '0;
        fill_q    <= '0;
        pipe_q    <= '0;
        bc_q      <= '0;
        bc_full_q <= 1'b0;
        ovf_chk_q <= 1'b0;
        arm_q     <= 1'b0;
        acnt_q    <= '0;
        vf_q      <= 1'b0;
        eof_chk_q <= 1'b0;
      end else begin
        hist_q    <= hist_d;
        fill_q    <= fill_d;
        pipe_q    <= pipe_d;
        bc_q      <= bc_d;
        bc_full_q <= bc_full_d;
        ovf_chk_q <= ovf_chk_d;
        arm_q     <= arm_d;
        acnt_q    <= acnt_d;
        vf_q      <= vf_d;
        eof_chk_q <= eof_chk_d;
      end
    end

    assign err_flag[gi]    = pipe_q[FLAG_LAT-1] ^ mon.Rx_FlagDetect[gi];
    assign err_abort[gi]   = ch_err_abort;
    assign err_eof[gi]     = eof_chk_q && !mon.Rx_EoF[gi];
    assign err_ovf[gi]     = ovf_chk_q && !mon.Rx_Overflow[gi];
    assign frame_close[gi] = close_evt;
  end

  function automatic logic [PC_W-1:0] popcnt(input logic [CHANNELS-1:0] v);
    popcnt = '0;
    for (int i = 0; i < CHANNELS; i++) popcnt = popcnt + PC_W'(v[i]);
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] base,
                                               input logic [PC_W-1:0]  inc);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(base) + SUM_W'(inc);
    sat_add = (sum > SUM_W'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
  endfunction

  logic [CHANNELS-1:0] strobe [5];
  logic [CNT_W-1:0]    cnt_q  [5];
  logic [CNT_W-1:0]    cnt_d  [5];
  logic [CHANNELS-1:0] sticky_q, sticky_d;

  assign strobe[0] = err_flag;
  assign strobe[1] = err_abort;
  assign strobe[2] = err_eof;
  assign strobe[3] = err_ovf;
  assign strobe[4] = frame_close;

  // Clear loads this cycle's increment so a coincident error is not lost.
  always_comb begin
    for (int k = 0; k < 5; k++) begin
      cnt_d[k] = sat_add(Clr ? '0 : cnt_q[k], popcnt(strobe[k]));
    end
    sticky_d = (Clr ? '0 : sticky_q) | err_flag | err_abort | err_eof | err_ovf;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int k = 0; k < 5; k++) cnt_q[k] <= '0;
      sticky_q <= '0;
    end else begin
      for (int k = 0; k < 5; k++) cnt_q[k] <= cnt_d[k];
      sticky_q <= sticky_d;
    end
  end

  assign mon.ErrFlagCnt  = cnt_q[0];
  assign mon.ErrAbortCnt = cnt_q[1];
  assign mon.ErrEoFCnt   = cnt_q[2];
  assign mon.ErrOvfCnt   = cnt_q[3];
  assign mon.FrameCnt    = cnt_q[4];
  assign mon.ErrSticky   = sticky_q;
endmodule

// File: tb/tb_hdlc_rx_monitor.sv
// Randomized bench: an event/deadline reference model predicts the monitor's
// totals each cycle; a separate monitor process pops and compares them.
module tb_hdlc_rx_monitor;
  localparam int CH    = 4;
  localparam int MB    = 16;
  localparam int FL    = 2;
  localparam int AW    = 2;
  localparam int CW    = 8;
  localparam int CMAX  = (1 << CW) - 1;
  localparam int HUNT  = 0;
  localparam int OPEN  = 1;
  localparam int FRAME = 2;

  typedef struct {
    int            due;
    int            cnt [5];
    logic [CH-1:0] sticky;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t expq[$];

  hdlc_rx_monitor_if #(.CHANNELS(CH), .CNT_W(CW)) bus ();

  hdlc_rx_monitor #(
    .CHANNELS(CH), .MAX_BYTES(MB), .FLAG_LAT(FL), .ABORT_WIN(AW), .CNT_W(CW)
  ) dut (
    .Clk(clk), .Rst(rst), .Clr(clr), .mon(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state (per channel)
  bit            rxbits  [CH][$];
  bit            seg     [CH][$];
  int            fdue    [CH][$];
  int            mode    [CH];
  int            nbytes  [CH];
  bit            armed   [CH];
  int            a_err_at[CH];
  int            as_at   [CH];
  int            eof_due [CH];
  int            ovf_due [CH];
  bit            vf_last [CH];
  logic [CH-1:0] prev_rx;
  bit            prev_rst;
  int            e_cnt   [5];
  logic [CH-1:0] e_sticky;

  function automatic bit pm(input int p);
    return $urandom_range(999) < p;
  endfunction

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic check(input string nm, input int act, input int exp, input int at);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s cycle %0d: got %0d expected %0d", nm, at, act, exp);
    end
  endtask

  task automatic push_bits(input int c, input logic [7:0] b, input int nb);
    for (int i = 7; i > 7 - nb; i--) seg[c].push_back(b[i]);
  endtask

  // Line content: flags, aborts, runs of ones, zero-sharing flag pairs, random bytes.
  task automatic refill(input int c);
    int r;
    r = $urandom_range(99);
    if (r < 18)      push_bits(c, 8'h7E, 8);
    else if (r < 24) push_bits(c, 8'h7F, 8);
    else if (r < 28) push_bits(c, 8'hFF, 8);
    else if (r < 33) begin
      push_bits(c, 8'h7E, 7);
      push_bits(c, 8'h7E, 8);
    end else         push_bits(c, 8'($urandom), 8);
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      rxbits[c].delete();
      fdue[c].delete();
      mode[c]     = HUNT;
      nbytes[c]   = 0;
      armed[c]    = 1'b0;
      a_err_at[c] = -1;
      as_at[c]    = -1;
      eof_due[c]  = -1;
      ovf_due[c]  = -1;
      vf_last[c]  = 1'b0;
    end
  endtask

  // One cycle: advance the model by last cycle's line bits, choose this cycle's
  // inputs (with optional faults), and queue the totals expected after the edge.
  task automatic do_cycle(input int n, input int fpm, input int rpm, input int cpm);
    int            inc [5];
    logic [CH-1:0] err_any;
    logic [7:0]    w;
    bit            fm, am, nb, exp_fd, fd, as_s, eof_s, ovf_s, vf_s;
    bit            e_f, e_a, e_e, e_o, e_fr;
    exp_t          e;
    if (prev_rst) model_reset();
    inc     = '{default: 0};
    err_any = '0;
    for (int c = 0; c < CH; c++) begin
      if (!prev_rst) begin
        rxbits[c].push_back(prev_rx[c]);
        if (rxbits[c].size() > 8) void'(rxbits[c].pop_front());
      end
      w = '0;
      for (int i = 0; i < rxbits[c].size(); i++) w = {w[6:0], rxbits[c][i]};
      fm = (rxbits[c].size() == 8) && (w == 8'h7E);
      am = (rxbits[c].size() == 8) && (w == 8'h7F);

      if (seg[c].size() == 0) refill(c);
      prev_rx[c] = seg[c].pop_front();
      nb = pm(500);

      exp_fd = (fdue[c].size() > 0) && (fdue[c][0] == n);
      if (exp_fd) void'(fdue[c].pop_front());
      fd  = exp_fd ^ pm(fpm / 4);
      e_f = (fd != exp_fd);

      as_s = armed[c] ? (n == as_at[c]) : pm(20);
      e_a  = 1'b0;
      if (armed[c]) begin
        if (n == a_err_at[c]) begin
          e_a      = 1'b1;
          armed[c] = 1'b0;
        end else if (as_s) begin
          armed[c] = 1'b0;
        end
      end

      eof_s = (eof_due[c] == n) ? !pm(fpm) : pm(30);
      e_e   = (eof_due[c] == n) && !eof_s;
      vf_s  = pm(125) ? !vf_last[c] : vf_last[c];
      if (vf_last[c] && !vf_s) eof_due[c] = n + 1;
      vf_last[c] = vf_s;

      ovf_s = (ovf_due[c] == n) ? !pm(fpm) : pm(30);
      e_o   = (ovf_due[c] == n) && !ovf_s;

      e_fr = 1'b0;
      case (mode[c])
        HUNT: if (fm) mode[c] = OPEN;
        OPEN: begin
          if (am) mode[c] = HUNT;
          else if (!fm && nb) begin
            mode[c]   = FRAME;
            nbytes[c] = 1;
          end
        end
        default: begin
          if (am) begin
            mode[c]     = HUNT;
            nbytes[c]   = 0;
            armed[c]    = 1'b1;
            a_err_at[c] = n + AW + 1;
            as_at[c]    = pm(fpm) ? -1 : n + $urandom_range(AW, 1);
          end else if (fm) begin
            mode[c]   = OPEN;
            nbytes[c] = 0;
            e_fr      = 1'b1;
          end else if (nb && nbytes[c] < MB + 1) begin
            nbytes[c]++;
            if (nbytes[c] == MB + 1) ovf_due[c] = n + 2;
          end
        end
      endcase
      if (fm) fdue[c].push_back(n + FL);

      bus.Rx[c]             = prev_rx[c];
      bus.Rx_NewByte[c]     = nb;
      bus.Rx_FlagDetect[c]  = fd;
      bus.Rx_AbortSignal[c] = as_s;
      bus.Rx_EoF[c]         = eof_s;
      bus.Rx_Overflow[c]    = ovf_s;
      bus.Rx_ValidFrame[c]  = vf_s;

      inc[0] += int'(e_f);
      inc[1] += int'(e_a);
      inc[2] += int'(e_e);
      inc[3] += int'(e_o);
      inc[4] += int'(e_fr);
      err_any[c] = e_f | e_a | e_e | e_o;
    end

    rst = pm(rpm);
    clr = pm(cpm);
    if (rst) begin
      for (int k = 0; k < 5; k++) e_cnt[k] = 0;
      e_sticky = '0;
    end else begin
      for (int k = 0; k < 5; k++) e_cnt[k] = clr ? sat(inc[k]) : sat(e_cnt[k] + inc[k]);
      e_sticky = (clr ? '0 : e_sticky) | err_any;
    end
    prev_rst = rst;
    e.due    = n + 1;
    e.cnt    = e_cnt;
    e.sticky = e_sticky;
    expq.push_back(e);
  endtask

  // Monitor: compare every output against the expectation due this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (expq.size() > 0 && expq[0].due <= cyc) begin
        e = expq.pop_front();
        check("ErrFlagCnt",  int'(bus.ErrFlagCnt),  e.cnt[0], e.due);
        check("ErrAbortCnt", int'(bus.ErrAbortCnt), e.cnt[1], e.due);
        check("ErrEoFCnt",   int'(bus.ErrEoFCnt),   e.cnt[2], e.due);
        check("ErrOvfCnt",   int'(bus.ErrOvfCnt),   e.cnt[3], e.due);
        check("FrameCnt",    int'(bus.FrameCnt),    e.cnt[4], e.due);
        check("ErrSticky",   int'(bus.ErrSticky),   int'(e.sticky), e.due);
      end
    end
  end

  int plen [4] = '{600, 1000, 1200, 1000};
  int pf   [4] = '{0, 50, 400, 100};
  int pr   [4] = '{0, 0, 0, 10};
  int pc   [4] = '{0, 10, 0, 30};

  initial begin
    exp_t e0;
    bus.Rx             = '0;
    bus.Rx_FlagDetect  = '0;
    bus.Rx_AbortSignal = '0;
    bus.Rx_EoF         = '0;
    bus.Rx_Overflow    = '0;
    bus.Rx_ValidFrame  = '0;
    bus.Rx_NewByte     = '0;
    prev_rx  = '0;
    prev_rst = 1'b1;
    for (int k = 0; k < 5; k++) e_cnt[k] = 0;
    e_sticky = '0;
    e0.due    = 1;
    e0.cnt    = e_cnt;
    e0.sticky = '0;
    expq.push_back(e0);

    for (int ph = 0; ph < 4; ph++) begin
      for (int k = 0; k < plen[ph]; k++) begin
        @(posedge clk);
        #1;
        do_cycle(cyc, pf[ph], pr[ph], pc[ph]);
      end
      $display("[TB] phase %0d to cycle %0d: frames=%0d flag=%0d abort=%0d eof=%0d ovf=%0d sticky=%b",
               ph, cyc, e_cnt[4], e_cnt[0], e_cnt[1], e_cnt[2], e_cnt[3], e_sticky);
    end

    repeat (3) @(negedge clk);
    check("queue_drained", expq.size(), 0, cyc);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
